// File: rtl/cont_ip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cont_ip_pkg
// Description : Shared constants, state encodings and helpers for the
//               counter IP AXI4-Lite slave.
// Revision    : 1.0 - initial release
// ============================================================================
package cont_ip_pkg;

  // Register byte offsets; only ADDR[3:2] distinguishes them
  localparam logic [3:0] CTRL_OFS  = 4'h0;
  localparam logic [3:0] LOAD_OFS  = 4'h4;
  localparam logic [3:0] COUNT_OFS = 4'h8;
  localparam logic [3:0] CMP_OFS   = 4'hC;

  // CTRL bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_DOWN  = 1;
  localparam int CTRL_IE    = 2;
  localparam int CTRL_CLR   = 3;
  localparam int CTRL_MATCH = 31;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_ACCEPT = 2'd1,
    WR_RESP   = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_ACCEPT = 2'd1,
    RD_DATA   = 2'd2
  } rd_state_t;

  // Byte-lane merge of a write into an existing 32-bit register value
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cont_core.sv
`default_nettype none
// ============================================================================
// Module      : cont_core
// Description : 32-bit up/down counter with load, clear, compare and a
//               sticky MATCH flag (set has priority over clear).
// Revision    : 1.0 - initial release
// ============================================================================
module cont_core
  import cont_ip_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic        i_down,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic [31:0] i_cmp,
  input  logic        i_match_clr,
  output logic [31:0] o_count,
  output logic        o_match
);

  logic [31:0] r_count;
  logic        r_match;

  // Count update: clear beats load beats step; arithmetic wraps modulo 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= i_down ? (r_count - 32'd1) : (r_count + 32'd1);
    end
  end

  // Sticky match flag; a new match in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_match <= 1'b0;
    end else if (i_en && (r_count == i_cmp)) begin
      r_match <= 1'b1;
    end else if (i_match_clr) begin
      r_match <= 1'b0;
    end
  end

  assign o_count = r_count;
  assign o_match = r_match;

endmodule
`default_nettype wire

// File: rtl/cont_ip_axi_slave.sv
`default_nettype none
// ============================================================================
// Module      : cont_ip_axi_slave
// Description : AXI4-Lite responder exposing the counter through CTRL, LOAD,
//               COUNT and CMP registers, with a level compare interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module cont_ip_axi_slave
  import cont_ip_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,   // only 32 is supported
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            irq
);

  wr_state_t   r_wr_state, w_wr_state_nxt;
  rd_state_t   r_rd_state, w_rd_state_nxt;
  logic        r_en, r_down, r_ie;
  logic [31:0] r_load, r_cmp, r_rdata;
  logic [1:0]  r_bresp;
  logic [1:0]  w_wr_sel, w_rd_sel;
  logic        w_wr_en, w_rd_en;
  logic        w_clr, w_load, w_match_clr, w_match;
  logic [31:0] w_load_val, w_count, w_rd_data;
  logic        w_unused;

  // Protection bits and the byte-offset bits inside a word carry no meaning here
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_wr_sel = S_AXI_AWADDR[3:2];
  assign w_rd_sel = S_AXI_ARADDR[3:2];

  // Write and read state registers
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_wr_state <= WR_IDLE;
      r_rd_state <= RD_IDLE;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_rd_state <= w_rd_state_nxt;
    end
  end

  // Write FSM: address and data are only taken together, response held until BREADY
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    S_AXI_AWREADY  = 1'b0;
    S_AXI_WREADY   = 1'b0;
    S_AXI_BVALID   = 1'b0;
    case (r_wr_state)
      WR_IDLE:   if (S_AXI_AWVALID && S_AXI_WVALID) w_wr_state_nxt = WR_ACCEPT;
      WR_ACCEPT: begin
        S_AXI_AWREADY  = 1'b1;
        S_AXI_WREADY   = 1'b1;
        w_wr_state_nxt = WR_RESP;
      end
      WR_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_wr_state_nxt = WR_IDLE;
      end
      default:   w_wr_state_nxt = WR_IDLE;
    endcase
  end

  // Read FSM: data captured during the ARREADY cycle, held until RREADY
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    S_AXI_ARREADY  = 1'b0;
    S_AXI_RVALID   = 1'b0;
    case (r_rd_state)
      RD_IDLE:   if (S_AXI_ARVALID) w_rd_state_nxt = RD_ACCEPT;
      RD_ACCEPT: begin
        S_AXI_ARREADY  = 1'b1;
        w_rd_state_nxt = RD_DATA;
      end
      RD_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) w_rd_state_nxt = RD_IDLE;
      end
      default:   w_rd_state_nxt = RD_IDLE;
    endcase
  end

  assign w_wr_en = (r_wr_state == WR_ACCEPT);
  assign w_rd_en = (r_rd_state == RD_ACCEPT);

  // Single-cycle strobes into the counter core, aligned with the write accept cycle
  assign w_clr       = w_wr_en && (w_wr_sel == CTRL_OFS[3:2]) && S_AXI_WSTRB[0]
                       && S_AXI_WDATA[CTRL_CLR];
  assign w_match_clr = w_wr_en && (w_wr_sel == CTRL_OFS[3:2]) && S_AXI_WSTRB[3]
                       && S_AXI_WDATA[CTRL_MATCH];
  assign w_load      = w_wr_en && (w_wr_sel == LOAD_OFS[3:2]);
  assign w_load_val  = strb_merge(r_load, S_AXI_WDATA, S_AXI_WSTRB);

  // Register file writes; COUNT is read-only and only changes the response code
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_en    <= 1'b0;
      r_down  <= 1'b0;
      r_ie    <= 1'b0;
      r_load  <= '0;
      r_cmp   <= '0;
      r_bresp <= RESP_OKAY;
    end else if (w_wr_en) begin
      r_bresp <= (w_wr_sel == COUNT_OFS[3:2]) ? RESP_SLVERR : RESP_OKAY;
      case (w_wr_sel)
        CTRL_OFS[3:2]: if (S_AXI_WSTRB[0]) begin
          r_en   <= S_AXI_WDATA[CTRL_EN];
          r_down <= S_AXI_WDATA[CTRL_DOWN];
          r_ie   <= S_AXI_WDATA[CTRL_IE];
        end
        LOAD_OFS[3:2]: r_load <= w_load_val;
        CMP_OFS[3:2]:  r_cmp  <= strb_merge(r_cmp, S_AXI_WDATA, S_AXI_WSTRB);
        default:       ;
      endcase
    end
  end

  // Read data selection; CLR and reserved CTRL bits always read as zero
  always_comb begin
    w_rd_data = '0;
    case (w_rd_sel)
      CTRL_OFS[3:2]: begin
        w_rd_data[CTRL_EN]    = r_en;
        w_rd_data[CTRL_DOWN]  = r_down;
        w_rd_data[CTRL_IE]    = r_ie;
        w_rd_data[CTRL_MATCH] = w_match;
      end
      LOAD_OFS[3:2]:  w_rd_data = r_load;
      COUNT_OFS[3:2]: w_rd_data = w_count;
      default:        w_rd_data = r_cmp;
    endcase
  end

  // Capture read data once per accepted read so it stays stable while RVALID is high
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_rdata <= '0;
    end else if (w_rd_en) begin
      r_rdata <= w_rd_data;
    end
  end

  cont_core u_core (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .i_en        (r_en),
    .i_down      (r_down),
    .i_clr       (w_clr),
    .i_load      (w_load),
    .i_load_val  (w_load_val),
    .i_cmp       (r_cmp),
    .i_match_clr (w_match_clr),
    .o_count     (w_count),
    .o_match     (w_match)
  );

  assign S_AXI_BRESP = r_bresp;
  assign S_AXI_RDATA = r_rdata;
  assign S_AXI_RRESP = RESP_OKAY;
  assign irq         = w_match & r_ie;

endmodule
`default_nettype wire

// File: tb/tb_cont_ip_axi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_cont_ip_axi_slave
// Description : Self-checking bench for the counter IP AXI4-Lite slave.
//               Reference model of the register map feeds response queues
//               that a bus monitor drains on every B/R handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cont_ip_axi_slave;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  cont_ip_axi_slave dut (
    .ACLK          (clk),
    .ARESETN       (rstn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .irq           (irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model of the register map ----------------
  logic        m_en, m_down, m_ie, m_match;
  logic [31:0] m_load, m_cmp, m_count;
  logic [31:0] exp_r[$];
  logic [1:0]  exp_b[$];

  function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s);
    logic [31:0] mask;
    for (int i = 0; i < 32; i++) mask[i] = s[i/8];
    return (o & ~mask) | (n & mask);
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return {m_match, 28'd0, m_ie, m_down, m_en};
      2'd1:    return m_load;
      2'd2:    return m_count;
      default: return m_cmp;
    endcase
  endfunction

  // One model step per clock, driven by the bus handshakes seen at the edge
  always @(posedge clk) begin : model
    logic wr_hs, rd_hs, nm;
    logic [1:0] wsel;
    logic [31:0] nc;
    if (!rstn) begin
      {m_en, m_down, m_ie, m_match} = 4'b0;
      m_load = 0; m_cmp = 0; m_count = 0;
      exp_r.delete();
      exp_b.delete();
    end else begin
      wr_hs = awvalid && wvalid && awready && wready;
      rd_hs = arvalid && arready;
      wsel  = awaddr[3:2];
      if (rd_hs) exp_r.push_back(m_read(araddr[3:2]));
      if (wr_hs) exp_b.push_back(wsel == 2'd2 ? 2'b10 : 2'b00);
      nm = m_match;
      if (wr_hs && wsel == 2'd0 && wstrb[3] && wdata[31]) nm = 1'b0;
      if (m_en && m_count == m_cmp) nm = 1'b1;
      nc = m_count;
      if (m_en) nc = m_down ? m_count - 32'd1 : m_count + 32'd1;
      if (wr_hs && wsel == 2'd1) nc = bytes_merge(m_load, wdata, wstrb);
      if (wr_hs && wsel == 2'd0 && wstrb[0] && wdata[3]) nc = 32'd0;
      if (wr_hs) begin
        case (wsel)
          2'd0:    if (wstrb[0]) {m_ie, m_down, m_en} = wdata[2:0];
          2'd1:    m_load = bytes_merge(m_load, wdata, wstrb);
          2'd3:    m_cmp  = bytes_merge(m_cmp, wdata, wstrb);
          default: ;
        endcase
      end
      m_count = nc;
      m_match = nm;
    end
  end

  // ---------------- monitor: pops expected responses on handshakes ----------------
  always @(negedge clk) begin
    if (rstn) begin
      chk("irq", {31'd0, irq}, {31'd0, m_match & m_ie});
      if (bvalid && bready) begin
        if (exp_b.size() == 0) chk("stray_bresp", 32'd1, 32'd0);
        else chk("bresp", {30'd0, bresp}, {30'd0, exp_b.pop_front()});
      end
      if (rvalid && rready) begin
        chk("rresp", {30'd0, rresp}, 32'd0);
        if (exp_r.size() == 0) chk("stray_rdata", 32'd1, 32'd0);
        else chk("rdata", rdata, exp_r.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_lead, input int bdly, output logic [1:0] resp);
    awaddr  = a;
    awprot  = 3'($urandom);
    awvalid = 1'b1;
    for (int i = 0; i < aw_lead; i++) begin
      step();
      chk("aw_alone_no_ready", {31'd0, awready}, 32'd0);
    end
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    step();
    chk("aw_w_ready", {30'd0, awready, wready}, 32'd3);
    step();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("awready_one_cycle", {31'd0, awready}, 32'd0);
    chk("bvalid_rise", {31'd0, bvalid}, 32'd1);
    for (int i = 0; i < bdly; i++) begin
      step();
      chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
    end
    resp   = bresp;
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("bvalid_fall", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] a, input int rdly, output logic [31:0] d);
    araddr  = a;
    arprot  = 3'($urandom);
    arvalid = 1'b1;
    step();
    chk("arready", {31'd0, arready}, 32'd1);
    step();
    arvalid = 1'b0;
    chk("arready_one_cycle", {31'd0, arready}, 32'd0);
    chk("rvalid_rise", {31'd0, rvalid}, 32'd1);
    d = rdata;
    for (int i = 0; i < rdly; i++) begin
      step();
      chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
      if (exp_r.size() != 0) chk("rdata_hold", rdata, exp_r[0]);
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("rvalid_fall", {31'd0, rvalid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  resp, resp2;
    logic [31:0] d, d2;
    rstn = 1'b0;
    {awvalid, wvalid, bready, arvalid, rready} = 5'b0;
    awaddr = 0; araddr = 0; awprot = 0; arprot = 0; wdata = 0; wstrb = 0;
    repeat (3) step();
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_bresp",   {30'd0, bresp},   32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_rresp",   {30'd0, rresp},   32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    chk("rst_irq",     {31'd0, irq},     32'd0);
    rstn = 1'b1;
    step();

    // CMP full write and byte-strobed write
    axi_write(4'hC, 32'h0000_0010, 4'hF, 0, 0, resp);
    chk("cmp_wr_okay", {30'd0, resp}, 32'd0);
    axi_read(4'hC, 0, d);
    chk("cmp_readback", d, 32'h0000_0010);
    axi_write(4'hC, 32'hFFFF_FFAA, 4'b0001, 0, 0, resp);
    axi_read(4'hC, 1, d);
    chk("cmp_strobe", d, 32'h0000_00AA);

    // Up-count wrap from 0xFFFFFFFE; first read lands two steps after enable
    axi_write(4'h4, 32'hFFFF_FFFE, 4'hF, 0, 0, resp);
    axi_write(4'h0, 32'h0000_0001, 4'hF, 0, 0, resp);
    axi_read(4'h8, 0, d);
    chk("wrap_first_read", d, 32'h0000_0000);
    for (int i = 0; i < 3; i++) axi_read(4'h8, i, d);

    // Down count onto CMP sets MATCH and irq; W1C clears while counting continues
    axi_write(4'h0, 32'h8000_0000, 4'hF, 0, 0, resp);
    axi_write(4'h4, 32'd5, 4'hF, 0, 0, resp);
    axi_write(4'hC, 32'd3, 4'hF, 0, 0, resp);
    axi_write(4'h0, 32'h0000_0007, 4'hF, 0, 0, resp);
    repeat (4) step();
    chk("irq_set", {31'd0, irq}, 32'd1);
    axi_read(4'h0, 0, d);
    chk("ctrl_match_set", d, 32'h8000_0007);
    axi_write(4'h0, 32'h8000_0007, 4'hF, 0, 0, resp);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    axi_read(4'h0, 0, d);
    chk("ctrl_match_w1c", d, 32'h0000_0007);
    axi_read(4'h8, 0, d);
    axi_read(4'h8, 2, d);

    // CLR zeroes and stops the count; COUNT writes are rejected
    axi_write(4'h0, 32'h0000_0008, 4'hF, 0, 0, resp);
    axi_read(4'h8, 0, d);
    chk("clr_count", d, 32'd0);
    axi_write(4'h8, 32'h0000_1234, 4'hF, 0, 0, resp);
    chk("count_wr_slverr", {30'd0, resp}, 32'h2);
    axi_read(4'h8, 0, d);
    chk("count_read_only", d, 32'd0);

    // Address leads data, slow BREADY, concurrent read
    fork
      axi_write(4'h4, 32'hCAFE_0001, 4'hF, 3, 5, resp);
      axi_read(4'hC, 2, d2);
    join
    chk("lead_wr_okay", {30'd0, resp}, 32'd0);
    axi_read(4'h4, 0, d);
    chk("lead_wr_load", d, 32'hCAFE_0001);

    // Randomized concurrent traffic against the model
    for (int it = 0; it < 60; it++) begin
      logic [3:0]  wa, ra, ws;
      logic [31:0] wd;
      int          wl, wb, rl;
      wa = 4'($urandom);
      ra = 4'($urandom);
      wd = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom;
      ws = ($urandom_range(1, 0) == 1) ? 4'hF : 4'($urandom);
      wl = $urandom_range(2, 0);
      wb = $urandom_range(3, 0);
      rl = $urandom_range(3, 0);
      fork
        axi_write(wa, wd, ws, wl, wb, resp2);
        axi_read(ra, rl, d2);
      join
    end

    // Reset with a write response pending
    awaddr = 4'h4; wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    step();
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    chk("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
    rstn = 1'b0;
    step();
    chk("midrst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("midrst_awready", {31'd0, awready}, 32'd0);
    chk("midrst_irq",     {31'd0, irq},     32'd0);
    rstn   = 1'b1;
    bready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_stray_bvalid", {31'd0, bvalid}, 32'd0);
    end
    bready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      axi_read(4'(r * 4), 0, d);
      chk("post_rst_reg_zero", d, 32'd0);
    end

    repeat (3) step();
    chk("scoreboard_drained", exp_b.size() + exp_r.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
